// File: rtl/pipe_register_elastic.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_register_elastic
//  Brief    : Multi-stage elastic pipeline register with valid/ready on both
//             sides. Supports per-stage stall with bubble collapse,
//             synchronous flush and a registered occupancy count.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_register_elastic #(
    parameter int                      DATA_WIDTH  = 4,
    parameter int                      DEPTH       = 3,
    parameter logic [DATA_WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_WIDTH-1:0]          data_i,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          data_o,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int c_CNT_W = $clog2(DEPTH + 1);

    // Per-stage state: stage 0 faces the input, stage DEPTH-1 drives the output.
    logic [DEPTH-1:0]       r_v;
    logic [DATA_WIDTH-1:0]  r_d [DEPTH];
    logic [c_CNT_W-1:0]     r_count;

    // Combinational control.
    logic [DEPTH-1:0]       w_mv;      // stage i hands its word onward this cycle
    logic [DEPTH-1:0]       w_load;    // stage i captures a new word this cycle
    logic [DEPTH-1:0]       w_v_nxt;   // stage valids after this edge
    logic [DATA_WIDTH-1:0]  w_src [DEPTH];
    logic                   w_push;
    logic [c_CNT_W-1:0]     w_count_nxt;

    // Advance chain: a stage moves when downstream is empty or itself moving.
    always_comb begin
        w_mv = '0;
        w_mv[DEPTH-1] = r_v[DEPTH-1] & out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            w_mv[i] = r_v[i] & (~r_v[i+1] | w_mv[i+1]);
        end
    end

    assign in_ready = ~flush & (~r_v[0] | w_mv[0]);
    assign w_push   = in_valid & in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign w_load[gi] = w_push;
                assign w_src[gi]  = data_i;
            end else begin : g_body
                assign w_load[gi] = w_mv[gi-1];
                assign w_src[gi]  = r_d[gi-1];
            end

            // A stage becomes valid on a load, otherwise empties when it moves on.
            assign w_v_nxt[gi] = w_load[gi] | (r_v[gi] & ~w_mv[gi]);

            // Data only changes on a transfer; draining leaves the old word in place.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_d[gi] <= RESET_VALUE;
                end else if (!flush && w_load[gi]) begin
                    r_d[gi] <= w_src[gi];
                end
            end
        end
    endgenerate

    // Popcount of the next valid vector so count tracks the valids edge-for-edge.
    always_comb begin
        w_count_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_count_nxt = w_count_nxt + c_CNT_W'(w_v_nxt[i]);
        end
    end

    // Valid and occupancy registers; reset dominates flush, flush dominates advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v     <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_v     <= '0;
            r_count <= '0;
        end else begin
            r_v     <= w_v_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign out_valid = r_v[DEPTH-1];
    assign data_o    = r_d[DEPTH-1];
    assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_pipe_register_elastic.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_register_elastic
//  Brief    : Directed stimulus with a scoreboard queue for the elastic
//             pipeline register (DEPTH=3, DATA_WIDTH=4, RESET_VALUE=4'hA).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_register_elastic;

    localparam int              c_DW    = 4;
    localparam int              c_DEPTH = 3;
    localparam logic [c_DW-1:0] c_RV    = 4'hA;
    localparam int              c_TOTAL = 12;   // words expected at the output

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [c_DW-1:0] data_i;
    logic            out_valid;
    logic            out_ready;
    logic [c_DW-1:0] data_o;
    logic [1:0]      count;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pops  = 0;

    logic [c_DW-1:0] sb_q [$];
    logic [c_DW-1:0] sb_exp;

    pipe_register_elastic #(
        .DATA_WIDTH  (c_DW),
        .DEPTH       (c_DEPTH),
        .RESET_VALUE (c_RV)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_i    (data_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_o    (data_o),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: mid-cycle, inputs and outputs are stable for the coming edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_tests++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: data_o=%0h delivered, required no output", data_o);
                end else begin
                    sb_exp = sb_q.pop_front();
                    n_pops++;
                    if (data_o !== sb_exp) begin
                        n_fail++;
                        $display("FAIL sb_data: data_o=%0h required=%0h", data_o, sb_exp);
                    end
                end
            end
            if (flush) begin
                sb_q.delete();
            end else if (in_valid && in_ready) begin
                sb_q.push_back(data_i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; data_i = '0;

        // T1 reset
        tick(); tick();
        #1;
        check("t1_out_valid", 32'(out_valid), 32'd0);
        check("t1_data_o",    32'(data_o),    32'hA);
        check("t1_count",     32'(count),     32'd0);
        check("t1_in_ready",  32'(in_ready),  32'd1);
        rst_n = 1'b1;

        // T2 stream 1..4, latency DEPTH
        out_ready = 1'b1; in_valid = 1'b1; data_i = 4'd1;
        tick(); data_i = 4'd2;
        tick(); data_i = 4'd3;
        tick();
        check("t2_latency_valid", 32'(out_valid), 32'd1);
        check("t2_latency_data",  32'(data_o),    32'd1);
        data_i = 4'd4;
        tick(); in_valid = 1'b0;
        check("t2_stream_data", 32'(data_o), 32'd2);
        tick(); tick(); tick();
        check("t2_drained_count", 32'(count),     32'd0);
        check("t2_drained_valid", 32'(out_valid), 32'd0);

        // T3 backpressure
        out_ready = 1'b0; in_valid = 1'b1; data_i = 4'd5;
        tick(); data_i = 4'd6;
        tick(); data_i = 4'd7;
        tick(); data_i = 4'd8;
        #1;
        check("t3_full_count",    32'(count),    32'd3);
        check("t3_full_in_ready", 32'(in_ready), 32'd0);
        check("t3_full_data",     32'(data_o),   32'd5);
        tick();
        check("t3_hold_data",  32'(data_o), 32'd5);
        check("t3_hold_count", 32'(count),  32'd3);
        out_ready = 1'b1;
        #1;
        check("t3_pushpop_in_ready", 32'(in_ready), 32'd1);
        tick();
        out_ready = 1'b0; in_valid = 1'b0;
        check("t3_pushpop_count", 32'(count),  32'd3);
        check("t3_pushpop_data",  32'(data_o), 32'd6);
        out_ready = 1'b1;
        tick(); tick(); tick();
        check("t3_drained_count", 32'(count), 32'd0);

        // T4 bubble collapse
        out_ready = 1'b0; in_valid = 1'b1; data_i = 4'd9;
        tick(); in_valid = 1'b0;
        check("t4_one_count", 32'(count),     32'd1);
        check("t4_not_yet",   32'(out_valid), 32'd0);
        tick(); tick();
        check("t4_arrive_valid", 32'(out_valid), 32'd1);
        check("t4_arrive_data",  32'(data_o),    32'd9);
        in_valid = 1'b1; data_i = 4'd10;
        tick(); in_valid = 1'b0;
        tick();
        check("t4_stack_count", 32'(count),  32'd2);
        check("t4_stack_data",  32'(data_o), 32'd9);
        out_ready = 1'b1;
        tick();
        check("t4_release_data", 32'(data_o), 32'd10);
        tick();
        check("t4_release_count", 32'(count), 32'd0);

        // T5 flush with two words in flight
        out_ready = 1'b0; in_valid = 1'b1; data_i = 4'd11;
        tick(); data_i = 4'd12;
        tick(); in_valid = 1'b0;
        tick();
        check("t5_pre_count", 32'(count), 32'd2);
        flush = 1'b1; in_valid = 1'b1; data_i = 4'd13;
        #1;
        check("t5_flush_in_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("t5_post_count", 32'(count),     32'd0);
        check("t5_post_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        tick(); tick(); tick();
        check("t5_nothing_out", 32'(out_valid), 32'd0);

        // T6 reset mid-stream
        out_ready = 1'b0; in_valid = 1'b1; data_i = 4'd1;
        tick(); data_i = 4'd2;
        tick(); data_i = 4'd3;
        tick(); in_valid = 1'b0;
        check("t6_pre_count", 32'(count), 32'd3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6_rst_count", 32'(count),     32'd0);
        check("t6_rst_data",  32'(data_o),    32'hA);
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1; in_valid = 1'b1; data_i = 4'd5;
        tick(); data_i = 4'd6;
        tick(); in_valid = 1'b0;
        tick();
        check("t6_resume_data", 32'(data_o), 32'd5);
        tick(); tick(); tick();
        check("t6_end_count", 32'(count), 32'd0);

        // Scoreboard bookkeeping
        check("sb_queue_empty", 32'(sb_q.size()), 32'd0);
        check("sb_word_total",  32'(n_pops),      32'(c_TOTAL));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
